// File: rtl/symbol_demapper.sv
// Hard-decision BPSK / Gray-QPSK symbol demapper.
// Takes {I,Q} Q1.15 symbols, slices on the sign bits and packs the decided
// bits LSB-first into bytes.  A frame-final symbol flushes a partial byte
// (high bits zero).  Sticky status bits and a byte counter sit alongside.
`timescale 1ns/1ps

module symbol_demapper (
   input  logic        clk_bb,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   input  logic        cfg_enable,
   input  logic        cfg_qpsk,
   input  logic        cfg_sw_reset,
   input  logic        stat_clr,
   output logic        stat_running,
   output logic        stat_overflow,
   output logic        stat_partial,
   output logic [15:0] stat_bytes
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [3:0]  cnt_reg, cnt_next;          // decided bits held, 0..8
   logic [7:0]  acc_reg, acc_next;          // partially packed byte
   logic        mode_reg, mode_next;        // mode latched for current byte
   logic        out_valid_reg, out_valid_next;
   logic [7:0]  out_data_reg, out_data_next;
   logic        out_last_reg, out_last_next;

   logic        running_reg, running_next;
   logic        overflow_reg, overflow_next;
   logic        partial_reg, partial_next;
   logic [15:0] bytes_reg, bytes_next;

   // ------------------------------------------------------------------
   // Decision and packing
   // ------------------------------------------------------------------
   logic        in_xfer;
   logic        out_xfer;
   logic        eff_qpsk;
   logic        bit_first;
   logic        bit_second;
   logic [3:0]  cnt_plus1;
   logic [3:0]  cnt_sum;
   logic [7:0]  acc_merged;
   logic        byte_done;
   logic        partial_evt;
   logic        overflow_evt;

   // Input side stalls while a finished byte is still waiting; reset also
   // holds it low so nothing is taken before the first clean edge.
   assign in_ready = rst_n & cfg_enable & (~out_valid_reg | out_ready);
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid_reg & out_ready;

   // The mode is only sampled at the start of a byte, so a mid-byte change
   // of cfg_qpsk cannot split a QPSK pair across a byte boundary.
   assign eff_qpsk   = (cnt_reg == 4'd0) ? cfg_qpsk : mode_reg;

   // QPSK sends Q sign first, then I sign; BPSK only uses the I sign.
   assign bit_first  = eff_qpsk ? in_data[15] : in_data[31];
   assign bit_second = in_data[31];

   assign cnt_plus1  = cnt_reg + 4'd1;
   assign cnt_sum    = cnt_reg + (eff_qpsk ? 4'd2 : 4'd1);

   // Drop each decided bit into its slot; bits above the fill point stay
   // zero because the accumulator is cleared after every byte.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_pack
         assign acc_merged[gi] = acc_reg[gi]
                               | (bit_first & (cnt_reg == 4'(gi)))
                               | (eff_qpsk & bit_second & (cnt_plus1 == 4'(gi)));
      end
   endgenerate

   assign byte_done    = in_xfer & ((cnt_sum >= 4'd8) | in_last);
   assign partial_evt  = in_xfer & ~cfg_sw_reset & in_last & (cnt_sum < 4'd8);
   assign overflow_evt = in_valid & ~in_ready;

   // Next-state for the accumulator and the output holding register.
   always_comb begin
      cnt_next       = cnt_reg;
      acc_next       = acc_reg;
      mode_next      = mode_reg;
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      out_last_next  = out_last_reg;
      if (cfg_sw_reset) begin
         // Soft reset outranks any handshake on this edge.
         cnt_next       = 4'd0;
         acc_next       = 8'h00;
         mode_next      = 1'b0;
         out_valid_next = 1'b0;
      end else begin
         if (out_xfer) begin
            out_valid_next = 1'b0;
         end
         if (in_xfer) begin
            mode_next = eff_qpsk;
            if (byte_done) begin
               // Reload straight away even if the old byte leaves now.
               cnt_next       = 4'd0;
               acc_next       = 8'h00;
               out_data_next  = acc_merged;
               out_last_next  = in_last;
               out_valid_next = 1'b1;
            end else begin
               cnt_next = cnt_sum;
               acc_next = acc_merged;
            end
         end
      end
   end

   // Next-state for the sticky status bits; a set/count beats stat_clr.
   always_comb begin
      running_next  = running_reg;
      overflow_next = overflow_reg;
      partial_next  = partial_reg;
      bytes_next    = bytes_reg;
      if (stat_clr) begin
         running_next  = 1'b0;
         overflow_next = 1'b0;
         partial_next  = 1'b0;
      end
      if (out_xfer) begin
         running_next = 1'b1;
         bytes_next   = bytes_reg + 16'd1;
      end else if (stat_clr) begin
         bytes_next   = 16'h0000;
      end
      if (overflow_evt) begin
         overflow_next = 1'b1;
      end
      if (partial_evt) begin
         partial_next = 1'b1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_bb or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg       <= 4'd0;
         acc_reg       <= 8'h00;
         mode_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= 8'h00;
         out_last_reg  <= 1'b0;
      end else begin
         cnt_reg       <= cnt_next;
         acc_reg       <= acc_next;
         mode_reg      <= mode_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         out_last_reg  <= out_last_next;
      end
   end

   // Status registers; untouched by the soft reset.
   always_ff @(posedge clk_bb or negedge rst_n) begin
      if (!rst_n) begin
         running_reg  <= 1'b0;
         overflow_reg <= 1'b0;
         partial_reg  <= 1'b0;
         bytes_reg    <= 16'h0000;
      end else begin
         running_reg  <= running_next;
         overflow_reg <= overflow_next;
         partial_reg  <= partial_next;
         bytes_reg    <= bytes_next;
      end
   end

   assign out_valid     = out_valid_reg;
   assign out_data      = out_data_reg;
   assign out_last      = out_last_reg;
   assign stat_running  = running_reg;
   assign stat_overflow = overflow_reg;
   assign stat_partial  = partial_reg;
   assign stat_bytes    = bytes_reg;

endmodule

// File: tb/tb_symbol_demapper.sv
// Testbench for symbol_demapper: directed symbol sequences, a bit-queue
// reference model, and a per-cycle comparison against that model.
`timescale 1ns/1ps

module tb_symbol_demapper;

   logic        clk_bb = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'h0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        out_last;
   logic        cfg_enable = 1'b1;
   logic        cfg_qpsk = 1'b0;
   logic        cfg_sw_reset = 1'b0;
   logic        stat_clr = 1'b0;
   logic        stat_running;
   logic        stat_overflow;
   logic        stat_partial;
   logic [15:0] stat_bytes;

   int n_checks = 0;
   int n_fail   = 0;

   symbol_demapper dut (
      .clk_bb        (clk_bb),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .cfg_enable    (cfg_enable),
      .cfg_qpsk      (cfg_qpsk),
      .cfg_sw_reset  (cfg_sw_reset),
      .stat_clr      (stat_clr),
      .stat_running  (stat_running),
      .stat_overflow (stat_overflow),
      .stat_partial  (stat_partial),
      .stat_bytes    (stat_bytes)
   );

   always #5 clk_bb = ~clk_bb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: decided bits queue up until eight exist or the
   // frame ends; finished bytes queue up until the sink takes them.
   // ------------------------------------------------------------------
   bit          bits_q[$];
   logic [8:0]  bytes_q[$];   // {last, data}
   bit          m_mode = 1'b0;
   bit          m_running = 1'b0;
   bit          m_ovf = 1'b0;
   bit          m_partial = 1'b0;
   logic [15:0] m_bytes = 16'h0;
   bit          m_rdy;
   bit          m_hs;
   logic [7:0]  m_b;

   always @(posedge clk_bb or negedge rst_n) begin
      if (!rst_n) begin
         bits_q.delete();
         bytes_q.delete();
         m_mode = 1'b0;
         m_running = 1'b0;
         m_ovf = 1'b0;
         m_partial = 1'b0;
         m_bytes = 16'h0;
      end else begin
         m_rdy = cfg_enable && (bytes_q.size() == 0 || out_ready);
         m_hs  = (bytes_q.size() != 0) && out_ready;
         if (stat_clr) begin
            m_running = 1'b0;
            m_ovf = 1'b0;
            m_partial = 1'b0;
            if (!m_hs) m_bytes = 16'h0;
         end
         if (m_hs) begin
            void'(bytes_q.pop_front());
            m_running = 1'b1;
            m_bytes = m_bytes + 16'd1;
         end
         if (in_valid && !m_rdy) m_ovf = 1'b1;
         if (cfg_sw_reset) begin
            bits_q.delete();
            bytes_q.delete();
         end else if (in_valid && m_rdy) begin
            if (bits_q.size() == 0) m_mode = cfg_qpsk;
            if (m_mode) begin
               bits_q.push_back(in_data[15]);
               bits_q.push_back(in_data[31]);
            end else begin
               bits_q.push_back(in_data[31]);
            end
            if (bits_q.size() >= 8 || in_last) begin
               m_b = 8'h00;
               foreach (bits_q[k]) m_b[k] = bits_q[k];
               bytes_q.push_back({in_last, m_b});
               if (bits_q.size() < 8) m_partial = 1'b1;
               bits_q.delete();
            end
         end
      end
   end

   // Compare every cycle, away from the active edge.
   logic exp_rdy;
   always @(negedge clk_bb) begin
      exp_rdy = rst_n && cfg_enable && (bytes_q.size() == 0 || out_ready);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(bytes_q.size() != 0));
      if (bytes_q.size() != 0) begin
         check("out_data", 32'(out_data), 32'(bytes_q[0][7:0]));
         check("out_last", 32'(out_last), 32'(bytes_q[0][8]));
      end else if (!rst_n) begin
         check("rst_out_data", 32'(out_data), 32'h0);
         check("rst_out_last", 32'(out_last), 32'h0);
      end
      check("stat_running", 32'(stat_running), 32'(m_running));
      check("stat_overflow", 32'(stat_overflow), 32'(m_ovf));
      check("stat_partial", 32'(stat_partial), 32'(m_partial));
      check("stat_bytes", 32'(stat_bytes), 32'(m_bytes));
   end

   // Present one symbol and hold it until accepted (bounded wait).
   task automatic send(input logic [15:0] i, input logic [15:0] q, input logic last);
      bit done;
      done = 1'b0;
      in_data  = {i, q};
      in_last  = last;
      in_valid = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk_bb);
         if (in_ready) begin
            @(posedge clk_bb);
            #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got no in_ready, expected acceptance of %0h", {i, q});
      end
   endtask

   task automatic tick();
      @(posedge clk_bb);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values, with enable high so in_ready must still be low.
      repeat (2) @(negedge clk_bb);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_stat_bytes", 32'(stat_bytes), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // QPSK frame -> 0xA5, last.
      out_ready = 1'b1;
      cfg_qpsk  = 1'b1;
      send(16'h5A82, 16'hA57E, 1'b0);
      send(16'h5A82, 16'hA57E, 1'b0);
      send(16'hA57E, 16'h5A82, 1'b0);
      send(16'hA57E, 16'h5A82, 1'b1);
      $display("qpsk frame: out_data=0x%0h out_last=%0d", out_data, out_last);
      check("qpsk_valid", 32'(out_valid), 32'h1);
      check("qpsk_data", 32'(out_data), 32'hA5);
      check("qpsk_last", 32'(out_last), 32'h1);
      tick();
      check("qpsk_bytes", 32'(stat_bytes), 32'h1);
      check("qpsk_running", 32'(stat_running), 32'h1);

      // BPSK partial frame -> 0x03, last, partial.
      cfg_qpsk = 1'b0;
      send(16'h8001, 16'h0000, 1'b0);
      send(16'h8001, 16'h0000, 1'b0);
      send(16'h7FFF, 16'h0000, 1'b1);
      $display("bpsk partial: out_data=0x%0h out_last=%0d", out_data, out_last);
      check("bpsk_data", 32'(out_data), 32'h03);
      check("bpsk_last", 32'(out_last), 32'h1);
      check("bpsk_partial", 32'(stat_partial), 32'h1);
      tick();

      // Backpressure and overflow.
      out_ready = 1'b0;
      send(16'h8000, 16'h0000, 1'b1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_data", 32'(out_data), 32'h01);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      $display("backpressure: out_data=0x%0h overflow=%0d", out_data, stat_overflow);
      check("bp_overflow", 32'(stat_overflow), 32'h1);
      check("bp_data_hold", 32'(out_data), 32'h01);
      out_ready = 1'b1;
      tick();
      check("bp_drained", 32'(out_valid), 32'h0);
      check("bp_ready_back", 32'(in_ready), 32'h1);

      // Clear status, then soft reset mid-byte, then 0x3C.
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("clr_bytes", 32'(stat_bytes), 32'h0);
      check("clr_overflow", 32'(stat_overflow), 32'h0);
      cfg_qpsk = 1'b1;
      send(16'h8000, 16'h8000, 1'b0);
      send(16'h8000, 16'h8000, 1'b0);
      cfg_sw_reset = 1'b1;
      tick();
      cfg_sw_reset = 1'b0;
      send(16'h0000, 16'h0000, 1'b0);
      send(16'h8000, 16'h8000, 1'b0);
      send(16'h8000, 16'h8000, 1'b0);
      send(16'h0000, 16'h0000, 1'b1);
      $display("sw_reset frame: out_data=0x%0h", out_data);
      check("swr_data", 32'(out_data), 32'h3C);
      check("swr_partial", 32'(stat_partial), 32'h0);
      tick();

      // BPSK zeros with Q negative and a mid-byte mode flip -> 0x00.
      cfg_qpsk = 1'b0;
      for (int k = 0; k < 8; k++) begin
         send(16'h0000, 16'h8000, 1'b0);
         cfg_qpsk = 1'b1;
      end
      $display("bpsk zeros: out_valid=%0d out_data=0x%0h", out_valid, out_data);
      check("zero_valid", 32'(out_valid), 32'h1);
      check("zero_data", 32'(out_data), 32'h00);
      check("zero_last", 32'(out_last), 32'h0);
      cfg_qpsk = 1'b0;
      tick();

      // Enable low keeps the partial byte -> 0x05.
      send(16'h8000, 16'h0000, 1'b0);
      cfg_enable = 1'b0;
      in_valid = 1'b1;
      repeat (2) tick();
      in_valid = 1'b0;
      cfg_enable = 1'b1;
      send(16'h0000, 16'h0000, 1'b0);
      send(16'h8000, 16'h0000, 1'b1);
      $display("enable gap: out_data=0x%0h", out_data);
      check("en_data", 32'(out_data), 32'h05);
      tick();

      // Reset mid-byte discards partial bits -> 0x02.
      send(16'h8000, 16'h0000, 1'b0);
      send(16'h8000, 16'h0000, 1'b0);
      send(16'h8000, 16'h0000, 1'b0);
      rst_n = 1'b0;
      #2;
      check("rst2_bytes", 32'(stat_bytes), 32'h0);
      check("rst2_valid", 32'(out_valid), 32'h0);
      tick();
      rst_n = 1'b1;
      send(16'h0000, 16'h0000, 1'b0);
      send(16'h8000, 16'h0000, 1'b1);
      $display("after reset: out_data=0x%0h", out_data);
      check("rst2_data", 32'(out_data), 32'h02);
      tick();

      // Byte counter wrap.
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      in_data  = 32'h8000_0000;
      in_last  = 1'b1;
      in_valid = 1'b1;
      repeat (65535) @(posedge clk_bb);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      $display("counter full: stat_bytes=0x%0h", stat_bytes);
      check("wrap_ffff", 32'(stat_bytes), 32'hFFFF);
      send(16'h8000, 16'h0000, 1'b1);
      tick();
      $display("counter wrap: stat_bytes=0x%0h", stat_bytes);
      check("wrap_zero", 32'(stat_bytes), 32'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/symbol_demapper.md
SYMBOL_DEMAPPER -- requirements
Module: symbol_demapper

Interface
REQ-001 The block SHALL provide clk_bb, input, 1: the single clock for all logic.
REQ-002 The block SHALL provide rst_n, input, 1: asynchronous active-low reset.
REQ-003 The block SHALL provide in_valid, input, 1: symbol valid.
REQ-004 The block SHALL provide in_ready, output, 1: symbol accepted on in_valid & in_ready.
REQ-005 The block SHALL provide in_data, input, 32: symbol {I[15:0], Q[15:0]}, signed Q1.15.
REQ-006 The block SHALL provide in_last, input, 1: final symbol of a frame.
REQ-007 The block SHALL provide out_valid, input/output as follows: out_valid output 1, out_ready input 1, out_data output 8 (bits LSB-first), out_last output 1.
REQ-008 The block SHALL provide cfg_enable, input, 1: 1 = datapath enabled.
REQ-009 The block SHALL provide cfg_qpsk, input, 1: 0 = BPSK, 1 = Gray QPSK.
REQ-010 The block SHALL provide cfg_sw_reset, input, 1: one-cycle pulse that clears datapath state.
REQ-011 The block SHALL provide stat_clr, input, 1: one-cycle pulse that clears the sticky status bits and the byte counter.
REQ-012 The block SHALL provide stat_running, stat_overflow and stat_partial, output, 1 each, as sticky status bits.
REQ-013 The block SHALL provide stat_bytes, output, 16: count of output bytes transferred.

Function
REQ-014 Hard decision SHALL use the sign bit only: a component with bit[15]=1 SHALL give bit 1; zero or positive SHALL give bit 0; magnitude SHALL be ignored.
REQ-015 BPSK SHALL produce one bit per symbol, equal to I[15]; Q SHALL be ignored.
REQ-016 QPSK SHALL produce two bits per symbol: first bit = Q[15], second bit = I[15].
- The mapping is 00:(+,+), 01:(-,+), 11:(-,-), 10:(+,-), written as (first,second):(I,Q).
REQ-017 Bits SHALL pack LSB-first: the first decided bit SHALL go to out_data[0].
REQ-018 The bit count SHALL range 0..8 and be held in a 4-bit counter.
REQ-019 The mode SHALL be latched when a symbol is accepted with bit count 0, and held until the byte completes; cfg_qpsk changes mid-byte SHALL have no effect on that byte.
REQ-020 in_ready SHALL equal cfg_enable & (~out_valid | out_ready).
REQ-021 A byte SHALL be loaded into the output register on the clock edge that accepts the symbol completing 8 bits; out_valid SHALL rise the following cycle (latency 1 cycle).
REQ-022 in_last on a symbol that completes exactly 8 bits SHALL set out_last=1 on that byte.
REQ-023 in_last on a symbol that leaves a partial byte SHALL emit that byte immediately, with unfilled high bits set to 0 and out_last=1, and SHALL set stat_partial.
REQ-024 The bit count SHALL return to 0 after every emitted byte.
REQ-025 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 When out_valid & out_ready and a new byte completes on the same edge, the output register SHALL reload with no bubble.
REQ-027 stat_overflow SHALL set when in_valid=1 and in_ready=0.
REQ-028 stat_running SHALL set on the first out_valid & out_ready.
REQ-029 stat_bytes SHALL increment on each out_valid & out_ready and SHALL wrap 0xFFFF to 0x0000.
REQ-030 stat_clr SHALL clear stat_running, stat_overflow, stat_partial and stat_bytes; a set or increment event in the same cycle SHALL win.
REQ-031 cfg_sw_reset SHALL clear the bit count, the accumulator, the latched mode and out_valid, with priority over a simultaneous handshake; the status outputs SHALL be unaffected.
REQ-032 cfg_enable=0 SHALL force in_ready=0, SHALL keep the partial accumulator, and SHALL still allow a pending output byte to drain.

Reset
REQ-033 While rst_n=0, the block SHALL drive in_ready=0, out_valid=0, out_data=0x00, out_last=0, stat_running=0, stat_overflow=0, stat_partial=0 and stat_bytes=0, and SHALL clear the bit count and the accumulator.
REQ-034 Reset asserted mid-byte SHALL discard the partial byte; the first symbol accepted after release SHALL fill bit 0.

Verification
REQ-035 The bench SHALL cover QPSK, out_ready=1: symbols (+23170,-23170), (+23170,-23170), (-23170,+23170), (-23170,+23170), in_last on the 4th -> one byte out_data=0xA5, out_last=1, stat_bytes=1.
REQ-036 The bench SHALL cover BPSK: I = -32767, -32767, +32767 with in_last on the 3rd -> out_data=0x03, out_last=1, stat_partial=1.
REQ-037 The bench SHALL cover backpressure: out_ready=0 with a byte pending -> in_ready=0, out_data stable; one extra in_valid -> stat_overflow=1; out_ready=1 -> byte transfers, in_ready=1 next cycle.
REQ-038 The bench SHALL cover cfg_sw_reset after 2 QPSK symbols, then 4 symbols encoding 0x3C -> out_data=0x3C with no residue from the earlier symbols.
REQ-039 The bench SHALL cover BPSK with I=0x0000 for 8 symbols -> out_data=0x00.
REQ-040 The bench SHALL cover stat_bytes at 0xFFFF plus one transfer -> stat_bytes=0x0000.
